// File: rtl/retire_trace_if.sv
// Retire-side inputs, trace record stream and status outputs of retire_trace_unit.
// rec_cycle_o exists only when TRACE_CYCLE_STAMP_EN is defined.
interface retire_trace_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 32
);
    logic              retire_i;
    logic [DATA_W-1:0] pc_i;
    logic              reg_write_i;
    logic [REG_AW-1:0] wreg_i;
    logic [DATA_W-1:0] wdata_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [DATA_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              halt_i;

    logic              rec_valid_o;
    logic              rec_ready_i;
    logic [2:0]        rec_kind_o;
    logic [CNT_W-1:0]  rec_inum_o;
    logic [DATA_W-1:0] rec_pc_o;
    logic [REG_AW-1:0] rec_reg_o;
    logic [DATA_W-1:0] rec_val_o;
    logic [DATA_W-1:0] rec_addr_o;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]  rec_cycle_o;
`endif

    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  inst_cnt_o;
    logic              halted_o;
    logic              timeout_o;
    logic              overflow_o;

    // Core + trace consumer side
    modport master (
        output retire_i, pc_i, reg_write_i, wreg_i, wdata_i,
        output mem_read_i, mem_write_i, mem_addr_i, mem_data_i, halt_i,
        output rec_ready_i,
        input  rec_valid_o, rec_kind_o, rec_inum_o, rec_pc_o, rec_reg_o,
        input  rec_val_o, rec_addr_o,
        input  cycle_cnt_o, inst_cnt_o, halted_o, timeout_o, overflow_o
`ifdef TRACE_CYCLE_STAMP_EN
        , input rec_cycle_o
`endif
    );

    // Trace unit side
    modport slave (
        input  retire_i, pc_i, reg_write_i, wreg_i, wdata_i,
        input  mem_read_i, mem_write_i, mem_addr_i, mem_data_i, halt_i,
        input  rec_ready_i,
        output rec_valid_o, rec_kind_o, rec_inum_o, rec_pc_o, rec_reg_o,
        output rec_val_o, rec_addr_o,
        output cycle_cnt_o, inst_cnt_o, halted_o, timeout_o, overflow_o
`ifdef TRACE_CYCLE_STAMP_EN
        , output rec_cycle_o
`endif
    );
endinterface

// File: rtl/retire_trace_unit.sv
// Retirement monitor: classifies retiring instructions, queues trace records in a
// fall-through FIFO, keeps saturating counters, halt and watchdog. Option: TRACE_CYCLE_STAMP_EN.
module retire_trace_unit #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int CNT_W      = 32,
    parameter int DEPTH      = 16,
    parameter int WDOG_LIMIT = 100000
) (
    input logic           clk,
    input logic           rst_n,
    retire_trace_if.slave tr
);
    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        KIND_NOP   = 3'd0,
        KIND_REG   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e             state;
    state_e             stateNext;
    logic               runEn;
    logic               halted;
    logic               timedOut;

    kind_e              kind;
    logic [REG_AW-1:0]  recReg;
    logic [DATA_W-1:0]  recVal;
    logic [DATA_W-1:0]  recAddr;

    logic [CNT_W-1:0]   cycleCnt;
    logic [CNT_W-1:0]   instCnt;
    logic               overflow;

    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W:0]     count;
    logic               pushReq;
    logic               pushOk;
    logic               popFire;

    logic [2:0]         kindMem [DEPTH];
    logic [CNT_W-1:0]   inumMem [DEPTH];
    logic [DATA_W-1:0]  pcMem   [DEPTH];
    logic [REG_AW-1:0]  regMem  [DEPTH];
    logic [DATA_W-1:0]  valMem  [DEPTH];
    logic [DATA_W-1:0]  addrMem [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]   cycMem  [DEPTH];
`endif

    // Record classification; a register write always outranks halt/store flags
    always_comb begin
        kind    = KIND_NOP;
        recReg  = '0;
        recVal  = '0;
        recAddr = '0;
        if (tr.reg_write_i && tr.mem_read_i) begin
            kind    = KIND_LOAD;
            recReg  = tr.wreg_i;
            recVal  = tr.wdata_i;
            recAddr = tr.mem_addr_i;
        end else if (tr.reg_write_i) begin
            kind    = KIND_REG;
            recReg  = tr.wreg_i;
            recVal  = tr.wdata_i;
        end else if (tr.halt_i) begin
            kind    = KIND_HALT;
        end else if (tr.mem_write_i) begin
            kind    = KIND_STORE;
            recVal  = tr.mem_data_i;
            recAddr = tr.mem_addr_i;
        end
    end

    // FIFO handshake; a full FIFO still takes a push when the head leaves on the same edge
    assign pushReq = runEn && tr.retire_i;
    assign popFire = (count != '0) && tr.rec_ready_i;
    assign pushOk  = pushReq && ((count != FULL_CNT) || popFire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Halt on the watchdog edge wins over the timeout
    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN: begin
                if (pushReq && (kind == KIND_HALT)) begin
                    stateNext = ST_HALTED;
                end else if (cycleCnt == WDOG_LAST) begin
                    stateNext = ST_TIMEOUT;
                end
            end
            default: stateNext = state;
        endcase
    end

    always_comb begin
        runEn    = 1'b0;
        halted   = 1'b0;
        timedOut = 1'b0;
        case (state)
            ST_RUN:     runEn    = 1'b1;
            ST_HALTED:  halted   = 1'b1;
            ST_TIMEOUT: timedOut = 1'b1;
            default:    runEn    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt <= '0;
            instCnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (runEn) begin
                cycleCnt <= satInc(cycleCnt);
            end
            if (pushReq) begin
                instCnt <= satInc(instCnt);
            end
            if (pushReq && !pushOk) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushOk, popFire})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage carries no reset; only entries behind a valid count are ever read
    always_ff @(posedge clk) begin
        if (pushOk) begin
            kindMem[wrPtr] <= kind;
            inumMem[wrPtr] <= instCnt;
            pcMem[wrPtr]   <= tr.pc_i;
            regMem[wrPtr]  <= recReg;
            valMem[wrPtr]  <= recVal;
            addrMem[wrPtr] <= recAddr;
`ifdef TRACE_CYCLE_STAMP_EN
            cycMem[wrPtr]  <= cycleCnt;
`endif
        end
    end

    assign tr.rec_valid_o = (count != '0);
    assign tr.rec_kind_o  = kindMem[rdPtr];
    assign tr.rec_inum_o  = inumMem[rdPtr];
    assign tr.rec_pc_o    = pcMem[rdPtr];
    assign tr.rec_reg_o   = regMem[rdPtr];
    assign tr.rec_val_o   = valMem[rdPtr];
    assign tr.rec_addr_o  = addrMem[rdPtr];
`ifdef TRACE_CYCLE_STAMP_EN
    assign tr.rec_cycle_o = cycMem[rdPtr];
`endif

    assign tr.cycle_cnt_o = cycleCnt;
    assign tr.inst_cnt_o  = instCnt;
    assign tr.halted_o    = halted;
    assign tr.timeout_o   = timedOut;
    assign tr.overflow_o  = overflow;
endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: directed scenarios plus random traffic against a queue model;
// a second instance with a short watchdog runs off the same retire stream.
module tb_retire_trace_unit;
    localparam int DATA_W     = 16;
    localparam int REG_AW     = 4;
    localparam int CNT_W      = 32;
    localparam int DEPTH      = 16;
    localparam int LIMIT_MAIN = 100000;
    localparam int LIMIT_W    = 8;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    retire_trace_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
    retire_trace_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) wbus ();

    assign wbus.retire_i    = bus.retire_i;
    assign wbus.pc_i        = bus.pc_i;
    assign wbus.reg_write_i = bus.reg_write_i;
    assign wbus.wreg_i      = bus.wreg_i;
    assign wbus.wdata_i     = bus.wdata_i;
    assign wbus.mem_read_i  = bus.mem_read_i;
    assign wbus.mem_write_i = bus.mem_write_i;
    assign wbus.mem_addr_i  = bus.mem_addr_i;
    assign wbus.mem_data_i  = bus.mem_data_i;
    assign wbus.halt_i      = 1'b0;
    assign wbus.rec_ready_i = 1'b1;

    retire_trace_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W),
        .DEPTH(DEPTH), .WDOG_LIMIT(LIMIT_MAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tr(bus)
    );

    retire_trace_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W),
        .DEPTH(DEPTH), .WDOG_LIMIT(LIMIT_W)
    ) dutW (
        .clk(clk), .rst_n(rst_n), .tr(wbus)
    );

    typedef struct {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] addr;
        logic [CNT_W-1:0]  cyc;
    } rec_t;

    rec_t             q[$];
    int               mMode;    // 0 running, 1 halted, 2 timed out
    int               wMode;
    logic [CNT_W-1:0] mCyc, mInst, wCyc, wInst;
    bit               mOvf;

    int checks   = 0;
    int failures = 0;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic int kindOf(input bit rw, input bit mr, input bit mw, input bit h);
        if (rw) return mr ? 2 : 1;
        if (h)  return 4;
        if (mw) return 3;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mMode = 0; wMode = 0;
        mCyc = '0; mInst = '0; wCyc = '0; wInst = '0;
        mOvf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        rec_t r;
        int   k;
        if (q.size() != 0 && bus.rec_ready_i) q.delete(0);
        if (mMode == 0) begin
            k = kindOf(bus.reg_write_i, bus.mem_read_i, bus.mem_write_i, bus.halt_i);
            if (bus.retire_i) begin
                r.kind = 3'(k);
                r.inum = mInst;
                r.pc   = bus.pc_i;
                r.rg   = (k == 1 || k == 2) ? bus.wreg_i : '0;
                r.val  = (k == 1 || k == 2) ? bus.wdata_i : (k == 3) ? bus.mem_data_i : '0;
                r.addr = (k == 2 || k == 3) ? bus.mem_addr_i : '0;
                r.cyc  = mCyc;
                if (q.size() < DEPTH) q.push_back(r);
                else mOvf = 1'b1;
                mInst = bump(mInst);
            end
            if (bus.retire_i && k == 4) mMode = 1;
            else if (mCyc == CNT_W'(LIMIT_MAIN - 1)) mMode = 2;
            mCyc = bump(mCyc);
        end
        if (wMode == 0) begin
            if (bus.retire_i) wInst = bump(wInst);
            if (wCyc == CNT_W'(LIMIT_W - 1)) wMode = 2;
            wCyc = bump(wCyc);
        end
    endtask

    task automatic checkAll();
        check("valid", bus.rec_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("kind", bus.rec_kind_o, q[0].kind);
            check("inum", bus.rec_inum_o, q[0].inum);
            check("pc", bus.rec_pc_o, q[0].pc);
            check("reg", bus.rec_reg_o, q[0].rg);
            check("val", bus.rec_val_o, q[0].val);
            check("addr", bus.rec_addr_o, q[0].addr);
`ifdef TRACE_CYCLE_STAMP_EN
            check("cycle_stamp", bus.rec_cycle_o, q[0].cyc);
`endif
        end
        check("cycle_cnt", bus.cycle_cnt_o, mCyc);
        check("inst_cnt", bus.inst_cnt_o, mInst);
        check("halted", bus.halted_o, mMode == 1);
        check("timeout", bus.timeout_o, mMode == 2);
        check("overflow", bus.overflow_o, mOvf);
        check("w_cycle_cnt", wbus.cycle_cnt_o, wCyc);
        check("w_inst_cnt", wbus.inst_cnt_o, wInst);
        check("w_timeout", wbus.timeout_o, wMode == 2);
        check("w_halted", wbus.halted_o, 1'b0);
        check("w_overflow", wbus.overflow_o, 1'b0);
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    // Called just after a falling edge; reset is asserted between clock edges
    task automatic doReset();
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        rst_n = 1'b1;
    endtask

    task automatic idle();
        bus.retire_i    = 1'b0;
        bus.pc_i        = '0;
        bus.reg_write_i = 1'b0;
        bus.wreg_i      = '0;
        bus.wdata_i     = '0;
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_data_i  = '0;
        bus.halt_i      = 1'b0;
    endtask

    task automatic drive(input logic [DATA_W-1:0] pc, input bit rw, input logic [REG_AW-1:0] wr,
                         input logic [DATA_W-1:0] wd, input bit mr, input bit mw,
                         input logic [DATA_W-1:0] ad, input logic [DATA_W-1:0] md, input bit h);
        bus.retire_i    = 1'b1;
        bus.pc_i        = pc;
        bus.reg_write_i = rw;
        bus.wreg_i      = wr;
        bus.wdata_i     = wd;
        bus.mem_read_i  = mr;
        bus.mem_write_i = mw;
        bus.mem_addr_i  = ad;
        bus.mem_data_i  = md;
        bus.halt_i      = h;
    endtask

    task automatic randRetire(input bit allowHalt);
        drive(DATA_W'($urandom), 1'($urandom), REG_AW'($urandom), DATA_W'($urandom),
              1'($urandom), 1'($urandom), DATA_W'($urandom), DATA_W'($urandom),
              allowHalt && ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        rst_n = 1'b1;
        bus.rec_ready_i = 1'b1;
        idle();
        modelReset();
        @(negedge clk);
        doReset();

        // Directed REG / STORE / HALT, then retires that must be ignored
        drive(16'h0000, 1'b1, 4'd3, 16'h00AA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step();
        check("tp_reg_kind", bus.rec_kind_o, 3'd1);
        check("tp_reg_inum", bus.rec_inum_o, 0);
        check("tp_reg_reg", bus.rec_reg_o, 4'd3);
        check("tp_reg_val", bus.rec_val_o, 16'h00AA);
        drive(16'h0002, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
        step();
        check("tp_st_kind", bus.rec_kind_o, 3'd3);
        check("tp_st_inum", bus.rec_inum_o, 1);
        check("tp_st_addr", bus.rec_addr_o, 16'h0010);
        check("tp_st_val", bus.rec_val_o, 16'h1234);
        drive(16'h0004, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        check("tp_halt_kind", bus.rec_kind_o, 3'd4);
        check("tp_halt_inum", bus.rec_inum_o, 2);
        for (int i = 0; i < 3; i++) begin
            randRetire(1'b0);
            step();
        end
        check("tp_inst_cnt", bus.inst_cnt_o, 3);
        check("tp_halted", bus.halted_o, 1'b1);
        idle();

        // LOAD record fields
        doReset();
        drive(16'h0006, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0020, 16'h5555, 1'b0);
        step();
        check("ld_kind", bus.rec_kind_o, 3'd2);
        check("ld_reg", bus.rec_reg_o, 4'd5);
        check("ld_val", bus.rec_val_o, 16'hBEEF);
        check("ld_addr", bus.rec_addr_o, 16'h0020);
        idle();

        // Overflow: 20 retires into a stalled FIFO, then drain in order
        doReset();
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            randRetire(1'b0);
            step();
        end
        check("ovf_flag", bus.overflow_o, 1'b1);
        check("ovf_inst", bus.inst_cnt_o, 20);
        idle();
        bus.rec_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_inum", bus.rec_inum_o, i);
            step();
        end
        check("drain_empty", bus.rec_valid_o, 1'b0);

        // Full FIFO with pop and push on the same edge
        doReset();
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            randRetire(1'b0);
            step();
        end
        bus.rec_ready_i = 1'b1;
        randRetire(1'b0);
        step();
        check("full_pp_ovf", bus.overflow_o, 1'b0);
        check("full_pp_head", bus.rec_inum_o, 1);
        idle();

        // Short watchdog instance: fires on the 8th running edge, then freezes
        doReset();
        for (int i = 0; i < LIMIT_W - 1; i++) step();
        check("wd_before", wbus.timeout_o, 1'b0);
        step();
        check("wd_fired", wbus.timeout_o, 1'b1);
        check("wd_cycle", wbus.cycle_cnt_o, LIMIT_W);
        for (int i = 0; i < 3; i++) step();
        check("wd_frozen", wbus.cycle_cnt_o, LIMIT_W);

`ifdef TRACE_CYCLE_STAMP_EN
        doReset();
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randRetire(1'b0);
            step();
        end
        idle();
        bus.rec_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stamp_seq", bus.rec_cycle_o, i);
            step();
        end
`endif

        // Asynchronous reset in the middle of a drain
        doReset();
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randRetire(1'b0);
            step();
        end
        idle();
        bus.rec_ready_i = 1'b1;
        step();
        doReset();
        check("mid_rst_valid", bus.rec_valid_o, 1'b0);
        check("mid_rst_inst", bus.inst_cnt_o, 0);

        // Random traffic with occasional halts and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) doReset();
            bus.rec_ready_i = 1'($urandom_range(0, 1));
            randRetire(1'b1);
            bus.retire_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) bus.halt_i = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Synthesizable retirement monitor for the CPU core, replacing bench-only trace and stats logic.
- Each cycle it classifies the retiring instruction and stamps it with an instruction number.
- It buffers trace records in a parametrised FIFO drained over a valid/ready port.
- It keeps cycle and instruction counters, detects halt, and raises a watchdog timeout. Sits beside the core top; fed from the writeback/memory stage.

Parameters:
DATA_W, 16, width of PC, register data, memory address and memory data
REG_AW, 4, register index width
CNT_W, 32, width of cycle/instruction counters and record instruction number
DEPTH, 16, trace FIFO entries; power of two, >= 2
WDOG_LIMIT, 100000, cycle count at which the watchdog fires

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
retire_i  in  1  one instruction retires this cycle
pc_i  in  DATA_W  PC of retiring instruction
reg_write_i  in  1  register file written
wreg_i  in  REG_AW  destination register
wdata_i  in  DATA_W  register write data
mem_read_i  in  1  load
mem_write_i  in  1  store
mem_addr_i  in  DATA_W  memory address
mem_data_i  in  DATA_W  store data
halt_i  in  1  halt instruction retiring
rec_valid_o  out  1  FIFO head valid
rec_ready_i  in  1  consumer accepts head
rec_kind_o  out  3  0 NOP/branch, 1 REG, 2 LOAD, 3 STORE, 4 HALT
rec_inum_o  out  CNT_W  instruction number, first retire = 0
rec_pc_o  out  DATA_W  PC
rec_reg_o  out  REG_AW  destination register (REG/LOAD), else 0
rec_val_o  out  DATA_W  wdata_i (REG/LOAD), mem_data_i (STORE), else 0
rec_addr_o  out  DATA_W  mem_addr_i (LOAD/STORE), else 0
cycle_cnt_o  out  CNT_W  cycles spent in RUN
inst_cnt_o  out  CNT_W  retired instructions counted
halted_o  out  1  halt seen
timeout_o  out  1  watchdog fired
overflow_o  out  1  sticky: at least one record dropped

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, counters 0, FIFO empty, rec_valid_o=0, halted_o=timeout_o=overflow_o=0.
- FSM states:
  - RUN: cycle_cnt increments every clock. If retire_i=1, the record is built and pushed, and inst_cnt increments; rec_inum = inst_cnt before increment.
  - Retire with kind HALT in RUN: RUN->HALTED on the same edge.
  - Watchdog: if cycle_cnt == WDOG_LIMIT-1 at an edge in RUN with no halt, RUN->TIMEOUT (cycle_cnt becomes WDOG_LIMIT). A retire on that edge is still recorded. Halt on that same edge wins: go HALTED.
  - HALTED and TIMEOUT: terminal. Counters are frozen, retire_i is ignored, the FIFO keeps draining. Only reset exits.
- Kind priority (per retire):
  - reg_write_i & mem_read_i -> LOAD
  - reg_write_i -> REG
  - halt_i -> HALT
  - mem_write_i -> STORE
  - otherwise -> NOP
- FIFO:
  - First-word fall-through: rec_*_o show the head combinationally; rec_valid_o = !empty.
  - Pop on rec_valid_o & rec_ready_i.
  - Push is accepted if not full, or if full with a pop on the same edge.
  - Otherwise the record is dropped, overflow_o is set (sticky), and inst_cnt still increments.
  - Pointers wrap modulo DEPTH; an explicit count or extra pointer bit distinguishes full from empty.
- Outputs are registered except the rec_* head fields. Latency: a retire at edge N is visible on rec_valid_o after edge N when the FIFO was empty.
- Counters saturate at all-ones, never wrap.

Optional Feature:
- Macro TRACE_CYCLE_STAMP_EN.
- When defined: extra output rec_cycle_o (CNT_W), holding cycle_cnt at the push edge (value before increment). The FIFO entry widens by CNT_W.
- When undefined: the port and storage are absent; everything else is identical.

Test Plan:
- Reset, then 3 retires: REG r3=0x00AA at PC 0x0000, STORE addr 0x0010 data 0x1234, HALT at 0x0004. rec_ready_i=1 -> records kind 1/3/4, inum 0/1/2; inst_cnt_o=3; halted_o=1; further retires ignored.
- LOAD: reg_write_i=mem_read_i=1, wreg=5, wdata 0xBEEF, addr 0x0020 -> kind 2, reg 5, val 0xBEEF, addr 0x0020.
- rec_ready_i=0, DEPTH=16, 20 retires -> 16 entries held, overflow_o=1, inst_cnt_o=20. Then drain -> inum 0..15 in order, then rec_valid_o=0.
- Full FIFO, rec_ready_i=1 and retire on same edge -> pop and push both occur, overflow_o stays 0.
- WDOG_LIMIT=8, no halt -> timeout_o=1 after the 8th edge in RUN, cycle_cnt_o=8 frozen.
- Assert rst_n=0 mid-drain with 5 entries -> immediately rec_valid_o=0, all counters 0, flags 0. With TRACE_CYCLE_STAMP_EN, retires on consecutive edges yield rec_cycle_o 0,1,2.
